// File: rtl/pbs_battle_datapath.sv
// Battle responder datapath: owns both HP registers and latched moves, drains damage one HP point per step.
// Latency k*DRAIN_CYCLES+2 cycles from the request edge; requests arriving while busy are dropped.
module pbs_battle_datapath #(
  parameter int HP_W         = 4,
  parameter int MAX_HP       = 15,
  parameter int DRAIN_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_pm,
  input  logic [1:0]      p_move,
  input  logic [1:0]      ai_move,
  input  logic            apply_damage,
  input  logic            active_trainer,
  input  logic            target,
  output logic [HP_W-1:0] p_hp,
  output logic [HP_W-1:0] ai_hp,
  output logic            busy,
  output logic            done,
  output logic            err_self_target,
  output logic            p_fainted,
  output logic            ai_fainted
);

  localparam int                CNT_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [HP_W-1:0]   HP_FULL  = HP_W'(MAX_HP);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [HP_W-1:0]   p_hp_q, p_hp_d, ai_hp_q, ai_hp_d;
  logic [1:0]        p_mv_q, p_mv_d, ai_mv_q, ai_mv_d;
  logic              apply_q;
  logic              tgt_q, tgt_d;
  logic [2:0]        pow_q, pow_d, rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              req, self_hit, step;
  logic [HP_W-1:0]   tgt_hp;

  function automatic logic [2:0] move_power(input logic [1:0] mv);
    return {1'b0, mv} + 3'd1;
  endfunction

  assign req      = apply_damage & ~apply_q;
  assign self_hit = (target == active_trainer);
  assign tgt_hp   = tgt_q ? ai_hp_q : p_hp_q;
  assign step     = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req && !self_hit) state_d = S_CALC;
      S_CALC:  state_d = (tgt_hp == '0) ? S_DONE : S_DRAIN;
      // The last step lands on the same edge that enters DONE.
      S_DRAIN: if (step && (rem_q == 3'd1 || tgt_hp == HP_W'(1))) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  always_comb begin
    p_hp_d  = p_hp_q;
    ai_hp_d = ai_hp_q;
    p_mv_d  = p_mv_q;
    ai_mv_d = ai_mv_q;
    tgt_d   = tgt_q;
    pow_d   = pow_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_pm) begin
          p_mv_d  = p_move;
          ai_mv_d = ai_move;
        end
        // Power comes from the moves latched before this edge, so a coincident load applies next time.
        if (req) begin
          if (self_hit) begin
            err_d = 1'b1;
          end else begin
            tgt_d = target;
            pow_d = move_power(active_trainer ? ai_mv_q : p_mv_q);
          end
        end
      end
      S_CALC: begin
        rem_d = pow_q;
        cnt_d = '0;
      end
      S_DRAIN: begin
        if (step) begin
          cnt_d = '0;
          rem_d = rem_q - 3'd1;
          if (tgt_hp != '0) begin
            if (tgt_q) ai_hp_d = ai_hp_q - HP_W'(1);
            else       p_hp_d  = p_hp_q - HP_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_hp_q  <= HP_FULL;
      ai_hp_q <= HP_FULL;
      p_mv_q  <= '0;
      ai_mv_q <= '0;
      apply_q <= 1'b0;
      tgt_q   <= 1'b0;
      pow_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      p_hp_q  <= p_hp_d;
      ai_hp_q <= ai_hp_d;
      p_mv_q  <= p_mv_d;
      ai_mv_q <= ai_mv_d;
      apply_q <= apply_damage;
      tgt_q   <= tgt_d;
      pow_q   <= pow_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign p_hp            = p_hp_q;
  assign ai_hp           = ai_hp_q;
  assign err_self_target = err_q;
  assign p_fainted       = (p_hp_q == '0);
  assign ai_fainted      = (ai_hp_q == '0);

endmodule

// File: tb/tb_pbs_battle_datapath.sv
// Bench for pbs_battle_datapath: two instances (drain 1 and drain 3 cycles) share stimulus,
// each attack window is recorded per cycle and compared against an HP/move model.
module tb_pbs_battle_datapath;
  localparam int W = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, load_pm, apply_damage, active_trainer, target;
  logic [1:0] p_move, ai_move;
  logic [3:0] php [2];
  logic [3:0] aihp [2];
  logic       busy [2];
  logic       done [2];
  logic       err [2];
  logic       pf [2];
  logic       af [2];

  pbs_battle_datapath #(.HP_W(4), .MAX_HP(15), .DRAIN_CYCLES(1)) u0 (
    .clk(clk), .reset(reset), .load_pm(load_pm), .p_move(p_move), .ai_move(ai_move),
    .apply_damage(apply_damage), .active_trainer(active_trainer), .target(target),
    .p_hp(php[0]), .ai_hp(aihp[0]), .busy(busy[0]), .done(done[0]),
    .err_self_target(err[0]), .p_fainted(pf[0]), .ai_fainted(af[0]));

  pbs_battle_datapath #(.HP_W(4), .MAX_HP(15), .DRAIN_CYCLES(3)) u1 (
    .clk(clk), .reset(reset), .load_pm(load_pm), .p_move(p_move), .ai_move(ai_move),
    .apply_damage(apply_damage), .active_trainer(active_trainer), .target(target),
    .p_hp(php[1]), .ai_hp(aihp[1]), .busy(busy[1]), .done(done[1]),
    .err_self_target(err[1]), .p_fainted(pf[1]), .ai_fainted(af[1]));

  int errors = 0;
  int checks = 0;

  // Per-cycle observations; index c = c-th falling edge after the request-sampling edge.
  logic [3:0] o_php  [2][0:W];
  logic [3:0] o_aihp [2][0:W];
  logic       o_busy [2][0:W];
  logic       o_done [2][0:W];
  logic       o_err  [2][0:W];

  // Model: hp[0]=player, hp[1]=AI; mv = latched move index per trainer.
  int m_hp [2];
  int m_mv [2];
  int dcs  [2] = '{1, 3};

  function automatic int k_of(input int att, input int tgt);
    int p;
    p = m_mv[att] + 1;
    return (p < m_hp[tgt]) ? p : m_hp[tgt];
  endfunction

  function automatic int first_done(input int d);
    int r;
    r = -1;
    for (int c = W; c >= 1; c--) if (o_done[d][c]) r = c;
    return r;
  endfunction

  function automatic int count_done(input int d);
    int n;
    n = 0;
    for (int c = 1; c <= W; c++) if (o_done[d][c]) n++;
    return n;
  endfunction

  function automatic int count_busy(input int d);
    int n;
    n = 0;
    for (int c = 1; c <= W; c++) if (o_busy[d][c]) n++;
    return n;
  endfunction

  function automatic int count_err(input int d);
    int n;
    n = 0;
    for (int c = 1; c <= W; c++) if (o_err[d][c]) n++;
    return n;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; apply_damage = 1'b0; load_pm = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_hp[0] = 15; m_hp[1] = 15; m_mv[0] = 0; m_mv[1] = 0;
  endtask

  task automatic load(input logic [1:0] lp, input logic [1:0] la);
    @(negedge clk);
    load_pm = 1'b1; p_move = lp; ai_move = la;
    @(negedge clk);
    load_pm = 1'b0;
    m_mv[0] = int'(lp); m_mv[1] = int'(la);
  endtask

  // hold: cycles apply stays high; re_c/load_c/rst_c: cycle at which to drive a re-edge,
  // load_pm (0 = together with the request) or reset for one edge (-1 = never).
  task automatic fire(input logic att, input logic tgt, input int hold, input int re_c,
                      input int load_c, input logic [1:0] lp, input logic [1:0] la, input int rst_c);
    @(negedge clk);
    active_trainer = att; target = tgt; apply_damage = 1'b1;
    if (load_c == 0) begin load_pm = 1'b1; p_move = lp; ai_move = la; end
    @(posedge clk);
    for (int c = 1; c <= W; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        o_php[d][c]  = php[d];
        o_aihp[d][c] = aihp[d];
        o_busy[d][c] = busy[d];
        o_done[d][c] = done[d];
        o_err[d][c]  = err[d];
      end
      active_trainer = ~att; target = ~tgt;
      apply_damage = (c < hold) || (c == re_c);
      load_pm = (c == load_c);
      if (c == load_c) begin p_move = lp; ai_move = la; end
      reset = (c == rst_c);
    end
    apply_damage = 1'b0; load_pm = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int d = 0; d < 2; d++) begin
      checks++; if (php[d] !== 4'd15) begin errors++; $display("FAIL reset_p_hp d=%0d got %0d exp 15", d, php[d]); end
      checks++; if (aihp[d] !== 4'd15) begin errors++; $display("FAIL reset_ai_hp d=%0d got %0d exp 15", d, aihp[d]); end
      checks++; if ({busy[d], done[d], err[d], pf[d], af[d]} !== 5'b0)
        begin errors++; $display("FAIL reset_flags d=%0d got %b exp 00000", d, {busy[d], done[d], err[d], pf[d], af[d]}); end
    end
  endtask

  task automatic test_basic();
    int exp_ai [6] = '{15, 15, 15, 14, 13, 12};
    do_reset();
    load(2'd2, 2'd0);
    fire(1'b0, 1'b1, 1, -1, -1, 2'd0, 2'd0, -1);
    for (int c = 2; c <= 5; c++) begin
      checks++; if (o_aihp[0][c] !== 4'(exp_ai[c]))
        begin errors++; $display("FAIL basic_ai_hp c=%0d got %0d exp %0d", c, o_aihp[0][c], exp_ai[c]); end
    end
    for (int c = 1; c <= 6; c++) begin
      checks++; if (o_busy[0][c] !== (c <= 5))
        begin errors++; $display("FAIL basic_busy c=%0d got %0b exp %0b", c, o_busy[0][c], c <= 5); end
    end
    checks++; if (first_done(0) != 5) begin errors++; $display("FAIL basic_done_at got %0d exp 5", first_done(0)); end
    checks++; if (count_done(0) != 1) begin errors++; $display("FAIL basic_done_cnt got %0d exp 1", count_done(0)); end
    checks++; if (o_php[0][W] !== 4'd15 || o_php[1][W] !== 4'd15)
      begin errors++; $display("FAIL basic_p_hp got %0d/%0d exp 15", o_php[0][W], o_php[1][W]); end
    checks++; if (o_aihp[1][W] !== 4'd12) begin errors++; $display("FAIL basic_ai_hp_dc3 got %0d exp 12", o_aihp[1][W]); end
  endtask

  task automatic test_faint();
    do_reset();
    load(2'd3, 2'd0);
    repeat (3) fire(1'b0, 1'b1, 1, -1, -1, 2'd0, 2'd0, -1);
    load(2'd0, 2'd0);
    fire(1'b0, 1'b1, 1, -1, -1, 2'd0, 2'd0, -1);
    checks++; if (o_aihp[0][W] !== 4'd2) begin errors++; $display("FAIL faint_setup got %0d exp 2", o_aihp[0][W]); end
    load(2'd3, 2'd0);
    fire(1'b0, 1'b1, 1, -1, -1, 2'd0, 2'd0, -1);
    for (int c = 2; c <= 6; c++) begin
      checks++; if (o_aihp[0][c] !== 4'((c >= 4) ? 0 : 4 - c))
        begin errors++; $display("FAIL faint_trace c=%0d got %0d exp %0d", c, o_aihp[0][c], (c >= 4) ? 0 : 4 - c); end
    end
    checks++; if (first_done(0) != 4) begin errors++; $display("FAIL faint_done_at got %0d exp 4", first_done(0)); end
    checks++; if (count_done(0) != 1) begin errors++; $display("FAIL faint_done_cnt got %0d exp 1", count_done(0)); end
    checks++; if (af[0] !== 1'b1 || pf[0] !== 1'b0)
      begin errors++; $display("FAIL faint_flags got p=%0b ai=%0b exp p=0 ai=1", pf[0], af[0]); end
    fire(1'b0, 1'b1, 1, -1, -1, 2'd0, 2'd0, -1);
    checks++; if (first_done(0) != 2 || first_done(1) != 2)
      begin errors++; $display("FAIL faint_zero_done_at got %0d/%0d exp 2", first_done(0), first_done(1)); end
    checks++; if (o_aihp[0][W] !== 4'd0) begin errors++; $display("FAIL faint_saturate got %0d exp 0", o_aihp[0][W]); end
  endtask

  task automatic test_self_target();
    do_reset();
    fire(1'b1, 1'b1, 1, -1, -1, 2'd0, 2'd0, -1);
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_err[d][1] !== 1'b1 || count_err(d) != 1)
        begin errors++; $display("FAIL self_err d=%0d got first=%0b cnt=%0d exp 1/1", d, o_err[d][1], count_err(d)); end
      checks++; if (count_busy(d) != 0 || count_done(d) != 0)
        begin errors++; $display("FAIL self_busy_done d=%0d got %0d/%0d exp 0/0", d, count_busy(d), count_done(d)); end
      checks++; if (o_php[d][W] !== 4'd15 || o_aihp[d][W] !== 4'd15)
        begin errors++; $display("FAIL self_hp d=%0d got %0d/%0d exp 15/15", d, o_php[d][W], o_aihp[d][W]); end
    end
  endtask

  task automatic test_hold();
    do_reset();
    load(2'd1, 2'd2);
    fire(1'b1, 1'b0, 20, -1, -1, 2'd0, 2'd0, -1);
    for (int d = 0; d < 2; d++) begin
      checks++; if (count_done(d) != 1) begin errors++; $display("FAIL hold_done_cnt d=%0d got %0d exp 1", d, count_done(d)); end
      checks++; if (o_php[d][W] !== 4'd12) begin errors++; $display("FAIL hold_p_hp d=%0d got %0d exp 12", d, o_php[d][W]); end
    end
  endtask

  task automatic test_ignored();
    do_reset();
    load(2'd3, 2'd1);
    fire(1'b0, 1'b1, 1, 3, 4, 2'd0, 2'd0, -1);
    checks++; if (first_done(0) != 6 || count_done(0) != 1)
      begin errors++; $display("FAIL ign_done got at=%0d cnt=%0d exp 6/1", first_done(0), count_done(0)); end
    checks++; if (o_aihp[0][W] !== 4'd11 || o_aihp[1][W] !== 4'd11)
      begin errors++; $display("FAIL ign_ai_hp got %0d/%0d exp 11", o_aihp[0][W], o_aihp[1][W]); end
    fire(1'b1, 1'b0, 1, -1, -1, 2'd0, 2'd0, -1);
    checks++; if (o_php[0][W] !== 4'd13) begin errors++; $display("FAIL ign_ai_move got p_hp %0d exp 13", o_php[0][W]); end
    fire(1'b0, 1'b1, 1, -1, -1, 2'd0, 2'd0, -1);
    checks++; if (o_aihp[0][W] !== 4'd7) begin errors++; $display("FAIL ign_p_move got ai_hp %0d exp 7", o_aihp[0][W]); end
  endtask

  task automatic test_simul_load();
    do_reset();
    load(2'd0, 2'd0);
    fire(1'b0, 1'b1, 1, -1, 0, 2'd3, 2'd3, -1);
    checks++; if (o_aihp[0][W] !== 4'd14) begin errors++; $display("FAIL simul_old_move got %0d exp 14", o_aihp[0][W]); end
    fire(1'b0, 1'b1, 1, -1, -1, 2'd0, 2'd0, -1);
    checks++; if (o_aihp[0][W] !== 4'd10) begin errors++; $display("FAIL simul_new_move got %0d exp 10", o_aihp[0][W]); end
  endtask

  task automatic test_drain3();
    int e;
    do_reset();
    load(2'd1, 2'd0);
    fire(1'b0, 1'b1, 1, -1, -1, 2'd0, 2'd0, -1);
    for (int c = 2; c <= 12; c++) begin
      e = 15 - (((c - 2) / 3 < 2) ? (c - 2) / 3 : 2);
      checks++; if (o_aihp[1][c] !== 4'(e))
        begin errors++; $display("FAIL dc3_trace c=%0d got %0d exp %0d", c, o_aihp[1][c], e); end
    end
    checks++; if (first_done(1) != 8 || count_done(1) != 1)
      begin errors++; $display("FAIL dc3_done got at=%0d cnt=%0d exp 8/1", first_done(1), count_done(1)); end
    checks++; if (o_busy[1][8] !== 1'b1 || o_busy[1][9] !== 1'b0)
      begin errors++; $display("FAIL dc3_busy got %0b%0b exp 10", o_busy[1][8], o_busy[1][9]); end
    checks++; if (first_done(0) != 4) begin errors++; $display("FAIL dc1_done_at got %0d exp 4", first_done(0)); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load(2'd3, 2'd3);
    fire(1'b0, 1'b1, 1, -1, -1, 2'd0, 2'd0, 4);
    m_hp[0] = 15; m_hp[1] = 15; m_mv[0] = 0; m_mv[1] = 0;
    checks++; if (o_aihp[0][4] !== 4'd13) begin errors++; $display("FAIL rmid_pre got %0d exp 13", o_aihp[0][4]); end
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_php[d][5] !== 4'd15 || o_aihp[d][5] !== 4'd15 || o_busy[d][5] !== 1'b0)
        begin errors++; $display("FAIL rmid_state d=%0d got p=%0d ai=%0d busy=%0b exp 15/15/0", d, o_php[d][5], o_aihp[d][5], o_busy[d][5]); end
      checks++; if (count_done(d) != 0) begin errors++; $display("FAIL rmid_done d=%0d got %0d exp 0", d, count_done(d)); end
    end
  endtask

  task automatic test_random();
    int att, tgt, k, hold;
    do_reset();
    for (int it = 0; it < 30; it++) begin
      if (m_hp[0] < 3 && m_hp[1] < 3) do_reset();
      if ($urandom_range(0, 1) == 1) load(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      att  = int'($urandom_range(0, 1));
      tgt  = ($urandom_range(0, 3) == 0) ? att : 1 - att;
      hold = int'($urandom_range(1, 3));
      fire(1'(att), 1'(tgt), hold, -1, -1, 2'd0, 2'd0, -1);
      k = (att == tgt) ? -1 : k_of(att, tgt);
      if (k >= 0) m_hp[tgt] -= k;
      for (int d = 0; d < 2; d++) begin
        checks++; if (first_done(d) != ((k < 0) ? -1 : k * dcs[d] + 2) || count_done(d) != ((k < 0) ? 0 : 1))
          begin errors++; $display("FAIL rnd_done it=%0d d=%0d got at=%0d cnt=%0d k=%0d", it, d, first_done(d), count_done(d), k); end
        checks++; if (count_err(d) != ((k < 0) ? 1 : 0))
          begin errors++; $display("FAIL rnd_err it=%0d d=%0d got %0d exp %0d", it, d, count_err(d), (k < 0) ? 1 : 0); end
        checks++; if (o_php[d][W] !== 4'(m_hp[0]) || o_aihp[d][W] !== 4'(m_hp[1]))
          begin errors++; $display("FAIL rnd_hp it=%0d d=%0d got %0d/%0d exp %0d/%0d", it, d, o_php[d][W], o_aihp[d][W], m_hp[0], m_hp[1]); end
        checks++; if (pf[d] !== (m_hp[0] == 0) || af[d] !== (m_hp[1] == 0))
          begin errors++; $display("FAIL rnd_faint it=%0d d=%0d got %0b%0b", it, d, pf[d], af[d]); end
      end
    end
  endtask

  initial begin
    reset = 1'b0; load_pm = 1'b0; apply_damage = 1'b0;
    active_trainer = 1'b0; target = 1'b1; p_move = 2'd0; ai_move = 2'd0;
    test_reset();
    test_basic();
    test_faint();
    test_self_target();
    test_hold();
    test_ignored();
    test_simul_load();
    test_drain3();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pbs_battle_datapath.md
Name: pbs_battle_datapath

Overview:
- Responder side of the battle control handshake: consumes `apply_damage`, `active_trainer` and `target` from the battle control FSM.
- Owns both Pokemon HP registers and each trainer's latched move selection.
- Applies move damage to the target's HP as a visible one-point-per-step drain.
- Returns `p_hp`, `ai_hp`, faint flags and a `done` pulse to the controller and display logic.

Parameters:
- HP_W, 4, width of each HP register.
- MAX_HP, 15, HP loaded at reset; must fit in HP_W bits.
- DRAIN_CYCLES, 1, clock cycles per HP point removed (≥1).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- load_pm  input  1  capture p_move/ai_move this cycle (honoured only when idle).
- p_move  input  2  player move index.
- ai_move  input  2  AI move index.
- apply_damage  input  1  damage request from control; rising edge triggers.
- active_trainer  input  1  attacker: 0 = player, 1 = AI.
- target  input  1  defender: 0 = player, 1 = AI.
- p_hp  output  HP_W  player Pokemon HP.
- ai_hp  output  HP_W  AI Pokemon HP.
- busy  output  1  high while an attack is being resolved.
- done  output  1  one-cycle pulse when an attack finishes.
- err_self_target  output  1  one-cycle pulse when a request has target == active_trainer.
- p_fainted  output  1  p_hp == 0.
- ai_fainted  output  1  ai_hp == 0.

Behaviour:
- Reset (sampled at posedge clk while reset=1):
  - p_hp = ai_hp = MAX_HP.
  - Latched moves = 0; apply_q = 0; state = IDLE.
  - busy, done, err_self_target = 0; fainted flags = 0.
  - Reset mid-attack aborts the attack: HP restored to MAX_HP, no done pulse.
- Move power table, fixed: index 0→1, 1→2, 2→3, 3→4.
- load_pm:
  - In IDLE, load_pm=1 latches p_move and ai_move at the clock edge.
  - Ignored in all other states.
- Request detection:
  - apply_q registers apply_damage; a request is apply_damage & ~apply_q.
  - A level held high triggers exactly once.
  - A level held high through reset triggers on the first edge after reset.
- FSM states: IDLE, CALC, DRAIN, DONE.
- IDLE (busy=0):
  - On a request with target != active_trainer: latch target, latch attacker power from the latched move of active_trainer, go to CALC.
  - On a request with target == active_trainer: err_self_target=1 next cycle, stay IDLE, no HP change, no done.
  - Requests arriving while not in IDLE are dropped, with no queueing.
  - active_trainer and target are sampled only at the accept edge.
- CALC (busy=1), one cycle:
  - remaining ← power; reset drain counter.
  - If the target HP is already 0, go to DONE; else go to DRAIN.
- DRAIN (busy=1):
  - Every DRAIN_CYCLES cycles, target HP −1 and remaining −1.
  - Go to DONE when remaining reaches 0 or target HP reaches 0.
  - HP saturates at 0 and never wraps.
- DONE: done=1 and busy=1 for one cycle, then IDLE.
- Latency:
  - From the request-sampling edge, done is high k·DRAIN_CYCLES+2 cycles later, where k = min(power, target HP).
  - If the target HP is already 0: done is high 2 cycles later.
- Simultaneous load_pm and accepted request in IDLE: the attack uses the previously latched move; the new moves take effect after.
- p_fainted and ai_fainted are decoded combinationally from the HP registers.
- The non-target HP never changes during an attack.

Test Plan:
- Reset; load_pm with p_move=2, ai_move=0; pulse apply_damage with active_trainer=0, target=1 → ai_hp steps 15→14→13→12 on consecutive cycles; done pulses 5 cycles after the sampling edge; p_hp stays 15.
- ai_hp=2, player move 3, attack AI → ai_hp drains 2→1→0 and stops; ai_fainted=1; done pulses 4 cycles after the sampling edge.
- active_trainer=1, target=1 → err_self_target pulses one cycle; busy stays 0; both HP unchanged; no done.
- apply_damage held high for 20 cycles → exactly one attack and one done pulse.
- A second rising edge during DRAIN, and load_pm during busy → both ignored; the HP result and the latched moves are unchanged.
- DRAIN_CYCLES=3, power 2 → HP decrements every 3 cycles; done 8 cycles after the sampling edge.
- Reset asserted mid-DRAIN → next cycle p_hp = ai_hp = 15, busy=0, no done pulse.
